axis_fifo_rr_scheduler: RTL and testbench
=========================================

Name: axis_fifo_rr_scheduler

Overview:
- N-input AXI-Stream arbiter that shares one downstream AXI-Stream FIFO (128-bit, common clock, wr_data_count exported as 32-bit data_count) between several packet producers.
- Round-robin, packet-atomic: once granted, a requester keeps the FIFO write port until its TLAST beat is accepted.
- Admission control: a new packet is only granted when the FIFO has room for a maximum-size packet, so a granted packet never stalls on FIFO full.
- Sits between DMA/command producers and the FIFO write port; the FIFO's M side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TDATA_WIDTH, 128, stream data width; must match the FIFO.
- FIFO_DEPTH, 256, depth of the downstream FIFO.
- MAX_PKT_BEATS, 16, maximum legal packet length in beats; also the admission threshold.
- ID_WIDTH, $clog2(NUM_REQ) (min 1), grant index width.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- S_AXIS_TDATA  in  NUM_REQ*TDATA_WIDTH  flattened requester data; requester i in slice i.
- S_AXIS_TKEEP  in  NUM_REQ*TDATA_WIDTH/8  flattened keep.
- S_AXIS_TLAST  in  NUM_REQ  per-requester last.
- S_AXIS_TVALID  in  NUM_REQ  per-requester valid.
- S_AXIS_TREADY  out  NUM_REQ  per-requester ready.
- M_AXIS_TDATA  out  TDATA_WIDTH  to FIFO s_axis.
- M_AXIS_TKEEP  out  TDATA_WIDTH/8  to FIFO.
- M_AXIS_TLAST  out  1  to FIFO.
- M_AXIS_TVALID  out  1  to FIFO.
- M_AXIS_TREADY  in  1  from FIFO.
- fifo_data_count  in  32  FIFO data_count (words written, not yet read).
- arb_enable  in  1  0 = finish the current packet, then issue no new grants.
- grant_id  out  ID_WIDTH  index of the current or last granted requester.
- busy  out  1  a packet is in flight.
- pkt_count  out  32  packets completed (wraps).
- overrun  out  1  sticky; a packet exceeded MAX_PKT_BEATS.

Behaviour:
- Reset (async assert, sync to aclk on release). State = IDLE, last_grant = NUM_REQ-1, grant_id = 0, beat_cnt = 0, pkt_count = 0, overrun = 0, busy = 0, M_AXIS_TVALID = 0, all S_AXIS_TREADY = 0.
- Free space: free = FIFO_DEPTH - fifo_data_count, computed at 32-bit width. If fifo_data_count > FIFO_DEPTH, free = 0 (saturate).
- space_ok = (free >= MAX_PKT_BEATS).
- State IDLE:
  - M_AXIS_TVALID = 0, all S_AXIS_TREADY = 0.
  - If arb_enable && space_ok && |S_AXIS_TVALID, pick the first requester with TVALID=1, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the pick as grant_id, clear beat_cnt, go to XFER.
  - Otherwise stay in IDLE.
- State XFER (combinational mux on grant_id):
  - M_AXIS_{TDATA,TKEEP,TLAST,TVALID} = S_AXIS_*[grant_id].
  - S_AXIS_TREADY[grant_id] = M_AXIS_TREADY; all other TREADY = 0.
  - busy = 1.
  - On each accepted beat (M_AXIS_TVALID && M_AXIS_TREADY), beat_cnt++.
  - On an accepted beat where TLAST=1 or beat_cnt == MAX_PKT_BEATS-1: last_grant <= grant_id, pkt_count++, go to IDLE.
  - If that beat has beat_cnt == MAX_PKT_BEATS-1 and TLAST=0: force M_AXIS_TLAST = 1 on that beat and set overrun = 1. The remainder of the source packet is arbitrated later as a new packet.
- Latency:
  - 1 cycle from TVALID seen in IDLE to the first beat presented on M.
  - One mandatory IDLE bubble cycle between consecutive packets.
  - No other added latency; data passes through combinationally.
- Boundary conditions:
  - Granted requester drops TVALID mid-packet: keep the grant, no timeout.
  - M_AXIS_TREADY low: hold, no state change.
  - fifo_data_count change during XFER: ignored, because admission is checked only in IDLE.
  - arb_enable falling during XFER: the current packet completes normally.
  - Single-beat packet (TLAST on the first beat): XFER lasts exactly 1 accepted beat.
  - Only one requester valid: it is re-granted after each bubble (fairness never blocks).
  - pkt_count wraps from 0xFFFFFFFF to 0.
  - Reset mid-packet: outputs drop immediately; the FIFO shares aresetn, so the partial packet is discarded.
- No combinational path from M_AXIS_TREADY to M_AXIS_TVALID.

Decomposition:
- Shared package axis_sched_pkg holds:
  - state encoding localparams ST_IDLE, ST_XFER;
  - function rr_pick(valid_vec, last_grant) returning the next index plus a found flag.
- One natural sub-module: rr_priority_picker (pure combinational rotate/priority-encode), reusable by other arbiters.
- The top instantiates the picker, the FSM, the counters and the mux.

Test Plan:
- Reset release with all 4 TVALID=1 and fifo_data_count=0 -> grant order 0,1,2,3,0. Each 4-beat packet arrives on M intact, with 1 idle cycle between packets; pkt_count=5 after 5 packets.
- fifo_data_count=241 (free=15 < 16) with requester 2 valid -> no grant, TREADY=0. Set count to 240 -> grant_id=2 on the next cycle and transfer starts.
- Requester 1 sends a 20-beat packet with no TLAST until beat 20 -> M_AXIS_TLAST forced on beat 16, overrun=1 (sticky). The remaining 4 beats are sent as a later packet; pkt_count increases by 2.
- Grant to 3 with M_AXIS_TREADY toggled randomly at 50%, and requester 0 TVALID asserted mid-packet -> requester 0 sees TREADY=0 until requester 3's TLAST is accepted. Requester 0 is granted next; no beats lost or duplicated.
- arb_enable deasserted on beat 2 of a 6-beat packet -> all 6 beats complete, then no grant while requesters stay valid. Re-enable -> arbitration resumes from last_grant+1.
- aresetn pulsed low on beat 3 of a packet -> M_AXIS_TVALID and all TREADY are 0 in the same cycle, with pkt_count=0, overrun=0 and state IDLE after release.

Source files
------------

// File: rtl/axis_sched_pkg.sv
// rtl/axis_sched_pkg.sv - shared state encoding and round-robin pick helper for stream schedulers
package axis_sched_pkg;

    // The helper works on a fixed-width request vector; callers zero-extend.
    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid_vec searching from last_grant+1 upward, wrapping at num_req.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid_vec,
        input logic [RR_IDX_W-1:0]   last_grant,
        input int                    num_req
    );
        rr_pick_t res;
        int       cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((k <= num_req) && !res.found && (cand < RR_MAX_REQ)) begin
                if (valid_vec[cand[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin rotate and priority encode
module rr_priority_picker
    import axis_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] pick,
    output logic                found
);

    logic [RR_MAX_REQ-1:0] valid_ext;
    logic [RR_IDX_W-1:0]   last_ext;
    rr_pick_t              res;
    logic                  unused_idx;

    // Widen the inputs to the helper's fixed width and run the search.
    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        last_ext                 = '0;
        last_ext[ID_WIDTH-1:0]   = last_grant;
        res                      = rr_pick(valid_ext, last_ext, NUM_REQ);
    end

    assign pick       = res.idx[ID_WIDTH-1:0];
    assign found      = res.found;
    assign unused_idx = ^res.idx;

endmodule

// File: rtl/axis_fifo_rr_scheduler.sv
// rtl/axis_fifo_rr_scheduler.sv - packet-atomic round-robin arbiter feeding one stream FIFO
module axis_fifo_rr_scheduler
    import axis_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TDATA_WIDTH   = 128,
    parameter int FIFO_DEPTH    = 256,
    parameter int MAX_PKT_BEATS = 16,
    parameter int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [NUM_REQ*TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [NUM_REQ-1:0]               S_AXIS_TLAST,
    input  logic [NUM_REQ-1:0]               S_AXIS_TVALID,
    output logic [NUM_REQ-1:0]               S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]         M_AXIS_TKEEP,
    output logic                             M_AXIS_TLAST,
    output logic                             M_AXIS_TVALID,
    input  logic                             M_AXIS_TREADY,
    input  logic [31:0]                      fifo_data_count,
    input  logic                             arb_enable,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             busy,
    output logic [31:0]                      pkt_count,
    output logic                             overrun
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);

    sched_state_t        state_q, state_d;
    logic [ID_WIDTH-1:0] last_grant;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [ID_WIDTH-1:0] pick_id;
    logic                pick_found;
    logic [31:0]         free_words;
    logic                space_ok;
    logic                beat_at_max;
    logic                grant_load;
    logic                beat_accept;
    logic                pkt_done;
    logic                force_last;

    logic [TDATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_W-1:0]      sel_tkeep;
    logic                   sel_tlast;
    logic                   sel_tvalid;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid      (S_AXIS_TVALID),
        .last_grant (last_grant),
        .pick       (pick_id),
        .found      (pick_found)
    );

    // Free FIFO space saturates at zero so a bogus count never wraps into a huge value.
    always_comb begin
        free_words = '0;
        if (fifo_data_count <= 32'(FIFO_DEPTH)) begin
            free_words = 32'(FIFO_DEPTH) - fifo_data_count;
        end
    end

    assign space_ok    = (free_words >= 32'(MAX_PKT_BEATS));
    assign beat_at_max = (beat_cnt == BEAT_W'(MAX_PKT_BEATS - 1));

    assign sel_tdata  = S_AXIS_TDATA[int'(grant_id)*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_tkeep  = S_AXIS_TKEEP[int'(grant_id)*KEEP_W +: KEEP_W];
    assign sel_tlast  = S_AXIS_TLAST[grant_id];
    assign sel_tvalid = S_AXIS_TVALID[grant_id];

    // State register; reset drops every handshake output in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the output mux; TVALID depends only on state and the source, never on TREADY.
    always_comb begin
        state_d       = state_q;
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = '0;
        busy          = 1'b0;
        grant_load    = 1'b0;
        beat_accept   = 1'b0;
        pkt_done      = 1'b0;
        force_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_enable && space_ok && pick_found) begin
                    grant_load = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                busy                    = 1'b1;
                M_AXIS_TDATA            = sel_tdata;
                M_AXIS_TKEEP            = sel_tkeep;
                M_AXIS_TVALID           = sel_tvalid;
                M_AXIS_TLAST            = sel_tlast | beat_at_max;
                S_AXIS_TREADY[grant_id] = M_AXIS_TREADY;
                beat_accept             = sel_tvalid & M_AXIS_TREADY;
                if (beat_accept && (sel_tlast || beat_at_max)) begin
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                end
                force_last = beat_accept & beat_at_max & ~sel_tlast;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant, beat and packet bookkeeping; an oversize packet is cut and flagged stickily.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt   <= '0;
            pkt_count  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (grant_load) begin
                grant_id <= pick_id;
                beat_cnt <= '0;
            end else if (beat_accept) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            if (pkt_done) begin
                last_grant <= grant_id;
                pkt_count  <= pkt_count + 32'd1;
            end
            if (force_last) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_rr_scheduler.sv
// tb/tb_axis_fifo_rr_scheduler.sv - scoreboard bench for the round-robin stream scheduler
module tb_axis_fifo_rr_scheduler;

    localparam int NR   = 4;
    localparam int DW   = 128;
    localparam int KW   = DW / 8;
    localparam int MAXB = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NR*DW-1:0]  S_AXIS_TDATA;
    logic [NR*KW-1:0]  S_AXIS_TKEEP;
    logic [NR-1:0]     S_AXIS_TLAST;
    logic [NR-1:0]     S_AXIS_TVALID;
    logic [NR-1:0]     S_AXIS_TREADY;
    logic [DW-1:0]     M_AXIS_TDATA;
    logic [KW-1:0]     M_AXIS_TKEEP;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY;
    logic [31:0]       fifo_data_count;
    logic              arb_enable;
    logic [1:0]        grant_id;
    logic              busy;
    logic [31:0]       pkt_count;
    logic              overrun;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } src_beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    id;
    } exp_beat_t;

    src_beat_t   src_q [NR][$];
    exp_beat_t   exp_q [$];
    logic [NR-1:0] hold;
    logic [NR-1:0] fire;
    bit          rdy_random;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          exp_pkts     = 0;

    always #5 aclk = ~aclk;

    axis_fifo_rr_scheduler #(
        .NUM_REQ       (NR),
        .TDATA_WIDTH   (DW),
        .FIFO_DEPTH    (256),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .S_AXIS_TDATA    (S_AXIS_TDATA),
        .S_AXIS_TKEEP    (S_AXIS_TKEEP),
        .S_AXIS_TLAST    (S_AXIS_TLAST),
        .S_AXIS_TVALID   (S_AXIS_TVALID),
        .S_AXIS_TREADY   (S_AXIS_TREADY),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TKEEP    (M_AXIS_TKEEP),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TREADY   (M_AXIS_TREADY),
        .fifo_data_count (fifo_data_count),
        .arb_enable      (arb_enable),
        .grant_id        (grant_id),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .overrun         (overrun)
    );

    function automatic logic [DW-1:0] mk_data(input int r, input int p, input int b);
        return {8'(r), 16'(p), 16'(b), 72'h0, 16'(b * 37 + r * 5 + p)};
    endfunction

    task automatic push_src(input int r, input int n, input int p);
        src_beat_t s;
        for (int b = 0; b < n; b++) begin
            s.data = mk_data(r, p, b);
            s.last = (b == n - 1);
            src_q[r].push_back(s);
        end
    endtask

    task automatic push_exp(input int r, input int n, input int p);
        exp_beat_t e;
        int        k;
        k = 0;
        for (int b = 0; b < n; b++) begin
            e.data = mk_data(r, p, b);
            e.last = (b == n - 1) || (k == MAXB - 1);
            e.id   = 2'(r);
            exp_q.push_back(e);
            if (e.last) begin
                k = 0;
                exp_pkts++;
            end else begin
                k++;
            end
        end
    endtask

    task automatic tick();
        exp_beat_t e;
        @(negedge aclk);
        for (int i = 0; i < NR; i++) begin
            if (fire[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            if ((src_q[i].size() > 0) && !hold[i]) begin
                S_AXIS_TVALID[i]          = 1'b1;
                S_AXIS_TLAST[i]           = src_q[i][0].last;
                S_AXIS_TDATA[i*DW +: DW]  = src_q[i][0].data;
                S_AXIS_TKEEP[i*KW +: KW]  = src_q[i][0].data[KW-1:0];
            end else begin
                S_AXIS_TVALID[i]          = 1'b0;
                S_AXIS_TLAST[i]           = 1'b0;
                S_AXIS_TDATA[i*DW +: DW]  = '0;
                S_AXIS_TKEEP[i*KW +: KW]  = '0;
            end
        end
        M_AXIS_TREADY = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        fire = S_AXIS_TVALID & S_AXIS_TREADY;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_beat: got data=%h id=%0d, required no beat", M_AXIS_TDATA, grant_id);
            end else begin
                e = exp_q.pop_front();
                if (M_AXIS_TDATA !== e.data || M_AXIS_TKEEP !== e.data[KW-1:0] ||
                    M_AXIS_TLAST !== e.last || grant_id !== e.id) begin
                    tests_failed++;
                    $display("FAIL beat: got data=%h keep=%h last=%b id=%0d, required data=%h keep=%h last=%b id=%0d",
                             M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, grant_id,
                             e.data, e.data[KW-1:0], e.last, e.id);
                end
            end
        end
    endtask

    task automatic drain(input int max_cycles, output int used);
        used = 0;
        while ((exp_q.size() != 0) && (used < max_cycles)) begin
            tick();
            used++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d beats outstanding after %0d cycles, required 0", exp_q.size(), used);
        end
        tick();
    endtask

    task automatic test_reset();
        aresetn         = 1'b0;
        S_AXIS_TDATA    = '0;
        S_AXIS_TKEEP    = '0;
        S_AXIS_TLAST    = '0;
        S_AXIS_TVALID   = '0;
        M_AXIS_TREADY   = 1'b1;
        fifo_data_count = 32'd0;
        arb_enable      = 1'b1;
        hold            = '0;
        fire            = '0;
        rdy_random      = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        tests_run++;
        if ({M_AXIS_TVALID, S_AXIS_TREADY, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL rst_handshake: got tvalid=%b tready=%b busy=%b, required all 0", M_AXIS_TVALID, S_AXIS_TREADY, busy);
        end
        tests_run++;
        if (grant_id !== 2'd0 || pkt_count !== 32'd0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_regs: got grant=%0d pkts=%0d overrun=%b, required 0 0 0", grant_id, pkt_count, overrun);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_round_robin();
        int used;
        push_src(0, 4, 1); push_src(1, 4, 2); push_src(2, 4, 3); push_src(3, 4, 4); push_src(0, 4, 5);
        push_exp(0, 4, 1); push_exp(1, 4, 2); push_exp(2, 4, 3); push_exp(3, 4, 4); push_exp(0, 4, 5);
        drain(200, used);
        tests_run++;
        if (used !== 25) begin
            tests_failed++;
            $display("FAIL rr_timing: got %0d cycles for 5x4 beats, required 25", used);
        end
        tests_run++;
        if (pkt_count !== 32'(exp_pkts) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_pkts: got pkts=%0d busy=%b, required pkts=%0d busy=0", pkt_count, busy, exp_pkts);
        end
    endtask

    task automatic test_admission();
        int used;
        fifo_data_count = 32'd241;
        push_src(2, 2, 6);
        push_exp(2, 2, 6);
        repeat (3) begin
            tick();
            tests_run++;
            if (S_AXIS_TREADY !== 4'b0 || M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL adm_blocked: got tready=%b tvalid=%b busy=%b, required 0 0 0", S_AXIS_TREADY, M_AXIS_TVALID, busy);
            end
        end
        fifo_data_count = 32'd240;
        tick();
        tests_run++;
        if (grant_id !== 2'd2 || busy !== 1'b1 || M_AXIS_TVALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL adm_grant: got grant=%0d busy=%b tvalid=%b, required 2 1 1", grant_id, busy, M_AXIS_TVALID);
        end
        fifo_data_count = 32'd255;
        drain(50, used);
        fifo_data_count = 32'd0;
        tests_run++;
        if (pkt_count !== 32'(exp_pkts)) begin
            tests_failed++;
            $display("FAIL adm_pkts: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_overrun();
        int used;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_before: got %b, required 0", overrun);
        end
        push_src(1, 20, 7);
        push_exp(1, 20, 7);
        drain(200, used);
        tests_run++;
        if (overrun !== 1'b1 || pkt_count !== 32'(exp_pkts)) begin
            tests_failed++;
            $display("FAIL ovr_after: got overrun=%b pkts=%0d, required 1 %0d", overrun, pkt_count, exp_pkts);
        end
    endtask

    task automatic test_backpressure();
        int n;
        rdy_random = 1'b1;
        push_src(3, 8, 8);
        push_exp(3, 8, 8);
        push_exp(0, 4, 9);
        tick();
        tick();
        push_src(0, 4, 9);
        n = 0;
        while ((exp_q.size() != 0) && (n < 400)) begin
            hold[3] = (n >= 2) && (n < 5);
            tick();
            if (busy && grant_id == 2'd3) begin
                tests_run++;
                if (S_AXIS_TREADY[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_isolation: got tready0=%b while req3 granted, required 0", S_AXIS_TREADY[0]);
                end
            end
            if (hold[3]) begin
                tests_run++;
                if (grant_id !== 2'd3 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_hold_grant: got grant=%0d busy=%b, required 3 1", grant_id, busy);
                end
            end
            n++;
        end
        hold       = '0;
        rdy_random = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
        tick();
        tests_run++;
        if (pkt_count !== 32'(exp_pkts) || overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_pkts: got pkts=%0d overrun=%b, required %0d 1", pkt_count, overrun, exp_pkts);
        end
    endtask

    task automatic test_arb_enable();
        int used;
        push_src(2, 6, 10);
        push_exp(2, 6, 10);
        tick();
        tick();
        tick();
        arb_enable = 1'b0;
        push_src(3, 4, 11);
        push_src(0, 4, 12);
        drain(50, used);
        repeat (5) begin
            tick();
            tests_run++;
            if (busy !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_idle: got busy=%b tvalid=%b while disabled, required 0 0", busy, M_AXIS_TVALID);
            end
        end
        tests_run++;
        if (grant_id !== 2'd2 || pkt_count !== 32'(exp_pkts)) begin
            tests_failed++;
            $display("FAIL en_hold: got grant=%0d pkts=%0d, required 2 %0d", grant_id, pkt_count, exp_pkts);
        end
        push_exp(3, 4, 11);
        push_exp(0, 4, 12);
        arb_enable = 1'b1;
        drain(100, used);
        tests_run++;
        if (pkt_count !== 32'(exp_pkts)) begin
            tests_failed++;
            $display("FAIL en_resume_pkts: got %0d, required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_reset_mid_packet();
        push_src(1, 6, 13);
        push_exp(1, 6, 13);
        repeat (5) tick();
        aresetn = 1'b0;
        #1;
        tests_run++;
        if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 4'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_rst_drop: got tvalid=%b tready=%b busy=%b, required 0 0 0", M_AXIS_TVALID, S_AXIS_TREADY, busy);
        end
        exp_q.delete();
        for (int i = 0; i < NR; i++) src_q[i].delete();
        fire     = '0;
        exp_pkts = 0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        tests_run++;
        if (pkt_count !== 32'd0 || overrun !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_rst_state: got pkts=%0d overrun=%b busy=%b grant=%0d, required 0 0 0 0",
                     pkt_count, overrun, busy, grant_id);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_admission();
        test_overrun();
        test_backpressure();
        test_arb_enable();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000ns, required summary");
        $fatal(1, "watchdog");
    end

endmodule
